swap_xfer_reg_file: RTL

//  Parametrised register file of 2**ADDR_WIDTH x DATA_WIDTH words.
//  - One synchronous write port and NUM_RD asynchronous read ports.
//  - A small transfer engine performs SWAP, COPY or CLEAR between two addresses.
//  - Engine operations are launched with a start/busy/done handshake.
//  - Sits in the datapath as scratch storage that control FSMs can reorder in place.

---
 rtl/swap_xfer_reg_file.sv | 131 +++++++++++++
 1 files changed

// File: rtl/swap_xfer_reg_file.sv
// rtl/swap_xfer_reg_file.sv - register file with SWAP/COPY/CLEAR transfer engine
// One sync write port, NUM_RD async read ports, start/busy/done engine.
module swap_xfer_reg_file #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        address_w,
  input  logic [DATA_WIDTH-1:0]        data_w,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] address_r,
  output logic [NUM_RD*DATA_WIDTH-1:0] data_r,
  input  logic                         start,
  input  logic [1:0]                   op,
  input  logic [ADDR_WIDTH-1:0]        address_A,
  input  logic [ADDR_WIDTH-1:0]        address_B,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [1:0] OP_SWAP  = 2'b00;
  localparam logic [1:0] OP_COPY  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WA,
    S_WB,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  tmp;
  logic [ADDR_WIDTH-1:0]  a_q, b_q;
  logic [1:0]             op_q;
  logic                   accept;
  logic                   tmp_load;
  logic                   err_nxt;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_wa;
  logic [DATA_WIDTH-1:0]  mem_wd;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign data_r[i*DATA_WIDTH +: DATA_WIDTH] = mem[address_r[i*ADDR_WIDTH +: ADDR_WIDTH]];
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      tmp   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      if (accept) begin
        a_q  <= address_A;
        b_q  <= address_B;
        op_q <= op;
      end
      if (tmp_load) tmp <= mem[a_q];
    end
  end

  // Single write port shared by the user (IDLE only) and the engine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tmp_load  = 1'b0;
    err_nxt   = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = address_w;
    mem_wd    = data_w;
    case (state)
      S_IDLE: begin
        mem_we = we;
        if (start) begin
          if (op == OP_SWAP || op == OP_COPY) begin
            accept    = 1'b1;
            state_nxt = (address_A == address_B) ? S_DONE : S_RD;
          end else if (op == OP_CLEAR) begin
            accept    = 1'b1;
            state_nxt = S_WA;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_RD: begin
        tmp_load  = 1'b1;
        state_nxt = (op_q == OP_SWAP) ? S_WA : S_WB;
      end
      S_WA: begin
        mem_we    = 1'b1;
        mem_wa    = a_q;
        mem_wd    = (op_q == OP_CLEAR) ? '0 : mem[b_q];
        state_nxt = (op_q == OP_CLEAR) ? S_DONE : S_WB;
      end
      S_WB: begin
        mem_we    = 1'b1;
        mem_wa    = b_q;
        mem_wd    = tmp;
        state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // A user write attempted while the engine owns the array is dropped.
    if (state != S_IDLE && we) err_nxt = 1'b1;
  end

endmodule
